// File: rtl/doodle_motion.sv
// Player-motion engine: x steering with wrap, ballistic y, landing, spring boost, scroll offset, game-over fall.
// Latency: all state updates one cycle after a frame_tick; outputs are the registers themselves.
// Backpressure: none; inputs are sampled only on the frame_tick cycle and ignored otherwise.
module doodle_motion #(
    parameter int X_W            = 11,
    parameter int Y_W            = 10,
    parameter int CNT_W          = 8,
    parameter int X_MIN          = 300,
    parameter int X_MAX          = 642,
    parameter int SPRITE_H       = 80,
    parameter int EARTH          = 600,
    parameter int START_X        = 472,
    parameter int VELOCITY       = 9,
    parameter int BOOST_VELOCITY = 15,
    parameter int ACCELERATION   = 2,
    parameter int SCROLL_STEP    = 12,
    parameter int SCROLL_FRAMES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [1:0]       game_state,
    input  logic [8:0]       delta_x,
    input  logic             land,
    input  logic [Y_W-1:0]   land_y,
    input  logic             spring,
    input  logic             scroll_start,
    output logic [X_W-1:0]   doodle_x,
    output logic [Y_W-1:0]   doodle_y,
    output logic             falling,
    output logic             facing_left,
    output logic [CNT_W-1:0] jump_n,
    output logic             fell_out,
    output logic             off_screen
);

    localparam int START_Y = EARTH - SPRITE_H - 1;
    localparam int Y_MAX   = (1 << Y_W) - 1;
    localparam int N_MAX   = (1 << CNT_W) - 1;
    localparam int SPAN    = X_MAX - X_MIN;
    localparam int SC_W    = $clog2(SCROLL_FRAMES + 1);
    localparam int VEL_W   = 8;

    localparam logic [1:0] GS_IDLE  = 2'd0;
    localparam logic [1:0] GS_PLAY  = 2'd1;
    localparam logic [1:0] GS_OVER  = 2'd2;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [Y_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [SC_W-1:0]  scroll_q, scroll_d;
    logic             falling_q, falling_d;
    logic             face_q, face_d;
    logic             fell_q, fell_d;
    logic             armed_q, armed_d;
    logic             off_q, off_d;

    // Ballistic working values
    logic [31:0]      n32, pos32, neg32, diff32;
    logic [Y_W-1:0]   bal_y;

    // Play-step working values
    logic signed [31:0] nx;
    logic [31:0]        lb32;
    logic               accept;
    logic               arm_now;
    logic [Y_W-1:0]     base_n, y_n;
    logic [SC_W-1:0]    sc_eff;
    logic [CNT_W-1:0]   n_inc;

    // Add one scroll step to a y value, saturating at the top of the y range
    function automatic logic [Y_W-1:0] scroll_add(input logic [Y_W-1:0] a);
        logic [31:0] s;
        s = 32'(a) + 32'(SCROLL_STEP);
        if (s > 32'(Y_MAX))
            return Y_W'(Y_MAX);
        return Y_W'(s);
    endfunction

    // Ballistic y for the current jump frame, clamped to the y range
    always_comb begin
        n32    = 32'(n_q);
        pos32  = 32'(base_q) + (32'(ACCELERATION) * n32 * n32) / 32'd20;
        neg32  = 32'(vel_q) * n32;
        diff32 = pos32 - neg32;
        if (neg32 > pos32)
            bal_y = '0;
        else if (diff32 > 32'(Y_MAX))
            bal_y = Y_W'(Y_MAX);
        else
            bal_y = Y_W'(diff32);
    end

    // Next-state for the whole engine, advanced only on frame ticks
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        n_d       = n_q;
        vel_d     = vel_q;
        scroll_d  = scroll_q;
        falling_d = falling_q;
        face_d    = face_q;
        fell_d    = 1'b0;
        armed_d   = armed_q;
        off_d     = off_q;
        nx        = '0;
        lb32      = 32'(land_y);
        accept    = 1'b0;
        arm_now   = armed_q;
        base_n    = base_q;
        y_n       = y_q;
        sc_eff    = scroll_q;
        n_inc     = (n_q == CNT_W'(N_MAX)) ? n_q : n_q + CNT_W'(1);

        if (frame_tick) begin
            case (game_state)
                GS_IDLE: begin
                    x_d       = X_W'(START_X);
                    y_d       = Y_W'(START_Y);
                    base_d    = Y_W'(START_Y);
                    n_d       = '0;
                    vel_d     = VEL_W'(VELOCITY);
                    scroll_d  = '0;
                    falling_d = 1'b0;
                    armed_d   = 1'b1;
                    off_d     = 1'b0;
                end
                GS_PLAY: begin
                    // Horizontal step with a single wrap across the play field
                    nx = $signed(32'(x_q)) + $signed({{23{delta_x[8]}}, delta_x});
                    if (nx < X_MIN)
                        nx = nx + SPAN;
                    else if (nx >= X_MAX)
                        nx = nx - SPAN;
                    x_d = X_W'(nx);

                    if (delta_x[8])
                        face_d = 1'b1;
                    else if (delta_x != '0)
                        face_d = 1'b0;

                    // Landing only counts on the way down
                    accept = land && falling_q;
                    if (accept) begin
                        base_n = (lb32 < 32'(SPRITE_H + 1)) ? '0 : Y_W'(lb32 - 32'(SPRITE_H + 1));
                        y_n    = base_n;
                        n_d    = CNT_W'(1);
                        vel_d  = VEL_W'(spring ? BOOST_VELOCITY : VELOCITY);
                    end else begin
                        y_n = bal_y;
                        n_d = n_inc;
                    end

                    // Scroll applies after landing so the new platform base is shifted too
                    sc_eff = scroll_start ? SC_W'(SCROLL_FRAMES) : scroll_q;
                    if (sc_eff != '0) begin
                        base_n   = scroll_add(base_n);
                        y_n      = scroll_add(y_n);
                        scroll_d = sc_eff - SC_W'(1);
                    end else begin
                        scroll_d = '0;
                    end

                    base_d    = base_n;
                    y_d       = y_n;
                    falling_d = (y_n > y_q);

                    // One fell_out pulse per fall, re-armed by a landing
                    arm_now = armed_q | accept;
                    if (arm_now && (32'(y_n) >= 32'(EARTH))) begin
                        fell_d  = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        armed_d = arm_now;
                    end
                end
                GS_OVER: begin
                    if (32'(bal_y) >= 32'(EARTH)) begin
                        y_d   = Y_W'(EARTH);
                        off_d = 1'b1;
                    end else begin
                        y_d = bal_y;
                        n_d = n_inc;
                    end
                    falling_d = (y_d > y_q);
                end
                default: begin
                    // Pause: everything holds
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            base_q    <= Y_W'(START_Y);
            n_q       <= '0;
            vel_q     <= VEL_W'(VELOCITY);
            scroll_q  <= '0;
            falling_q <= 1'b0;
            face_q    <= 1'b0;
            fell_q    <= 1'b0;
            armed_q   <= 1'b1;
            off_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            n_q       <= n_d;
            vel_q     <= vel_d;
            scroll_q  <= scroll_d;
            falling_q <= falling_d;
            face_q    <= face_d;
            fell_q    <= fell_d;
            armed_q   <= armed_d;
            off_q     <= off_d;
        end
    end

    assign doodle_x    = x_q;
    assign doodle_y    = y_q;
    assign falling     = falling_q;
    assign facing_left = face_q;
    assign jump_n      = n_q;
    assign fell_out    = fell_q;
    assign off_screen  = off_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Self-checking bench for doodle_motion: directed scenarios plus random play against an integer reference model.
// Each tick is followed by one quiet cycle so single-cycle pulses and between-tick don't-care inputs are exercised.
// Stimulus is driven #1 after the rising edge; outputs are compared at the same point.
module tb_doodle_motion;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [8:0]  delta_x;
    logic        land;
    logic [9:0]  land_y;
    logic        spring;
    logic        scroll_start;
    logic [10:0] doodle_x;
    logic [9:0]  doodle_y;
    logic        falling;
    logic        facing_left;
    logic [7:0]  jump_n;
    logic        fell_out;
    logic        off_screen;

    int checks = 0;
    int errors = 0;
    int fell_seen = 0;

    // Reference model state, plain integers
    int mx, my, mbase, mn, mvel, msc, mfall, mface, mfell, marm, moff;
    int saved_x;

    doodle_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_state   (game_state),
        .delta_x      (delta_x),
        .land         (land),
        .land_y       (land_y),
        .spring       (spring),
        .scroll_start (scroll_start),
        .doodle_x     (doodle_x),
        .doodle_y     (doodle_y),
        .falling      (falling),
        .facing_left  (facing_left),
        .jump_n       (jump_n),
        .fell_out     (fell_out),
        .off_screen   (off_screen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"},       32'(doodle_x),    32'(mx));
        chk({tag, "_y"},       32'(doodle_y),    32'(my));
        chk({tag, "_falling"}, 32'(falling),     32'(mfall));
        chk({tag, "_facing"},  32'(facing_left), 32'(mface));
        chk({tag, "_jump_n"},  32'(jump_n),      32'(mn));
        chk({tag, "_fell"},    32'(fell_out),    32'(mfell));
        chk({tag, "_off"},     32'(off_screen),  32'(moff));
    endtask

    task automatic model_reset();
        mx = 472; my = 519; mbase = 519; mn = 0; mvel = 9; msc = 0;
        mfall = 0; mface = 0; mfell = 0; marm = 1; moff = 0;
    endtask

    // Height of the jump arc: base - v*n + floor(a*n^2/20), kept on screen range
    function automatic int ballis();
        int v;
        v = mbase - mvel * mn + (2 * mn * mn) / 20;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    function automatic int clip(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_step(input int gs, input int dx, input bit ld, input int ly,
                              input bit sp, input bit ss);
        int ny, b, scl;
        bit acc;
        mfell = 0;
        if (gs == 0) begin
            mx = 472; my = 519; mbase = 519; mn = 0; mvel = 9; msc = 0;
            mfall = 0; marm = 1; moff = 0;
        end else if (gs == 1) begin
            mx = mx + dx;
            if (mx < 300) mx += 342;
            else if (mx >= 642) mx -= 342;
            if (dx < 0) mface = 1;
            else if (dx > 0) mface = 0;
            acc = ld && (mfall != 0);
            if (acc) begin
                mbase = (ly - 81 < 0) ? 0 : ly - 81;
                ny = mbase;
                mn = 1;
                mvel = sp ? 15 : 9;
                marm = 1;
            end else begin
                ny = ballis();
                if (mn < 255) mn++;
            end
            scl = ss ? 16 : msc;
            if (scl > 0) begin
                mbase = clip(mbase + 12);
                ny = clip(ny + 12);
                msc = scl - 1;
            end
            mfall = (ny > my) ? 1 : 0;
            my = ny;
            if (marm != 0 && ny >= 600) begin
                mfell = 1;
                marm = 0;
            end
        end else if (gs == 2) begin
            b = ballis();
            if (b >= 600) begin
                ny = 600;
                moff = 1;
            end else begin
                ny = b;
                if (mn < 255) mn++;
            end
            mfall = (ny > my) ? 1 : 0;
            my = ny;
        end
    endtask

    task automatic tick(input int gs, input int dx, input bit ld, input int ly,
                        input bit sp, input bit ss);
        game_state   = 2'(gs);
        delta_x      = 9'(dx);
        land         = ld;
        land_y       = 10'(ly);
        spring       = sp;
        scroll_start = ss;
        frame_tick   = 1'b1;
        @(posedge clk); #1;
        model_step(gs, dx, ld, ly, sp, ss);
        check_all("tick");
        if (fell_out) fell_seen++;
        frame_tick   = 1'b0;
        delta_x      = 9'($urandom);
        land         = 1'($urandom);
        land_y       = 10'($urandom);
        spring       = 1'($urandom);
        scroll_start = 1'($urandom);
        @(posedge clk); #1;
        mfell = 0;
        check_all("quiet");
        if (fell_out) fell_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int r, gs, guard;
        rst = 1'b1; frame_tick = 1'b0; game_state = 2'd0; delta_x = '0;
        land = 1'b0; land_y = '0; spring = 1'b0; scroll_start = 1'b0;

        // Reset values
        do_reset();
        chk("reset_y_const", 32'(doodle_y), 32'd519);

        // Free jump from the start position
        for (int k = 1; k <= 49; k++) begin
            tick(1, 0, 0, 0, 0, 0);
            if (k == 2)  chk("arc_n1",  32'(doodle_y), 32'd510);
            if (k == 6)  chk("arc_n5",  32'(doodle_y), 32'd476);
            if (k == 45) chk("arc_n44", 32'(doodle_y), 32'd316);
            if (k == 46) chk("arc_n45", 32'(doodle_y), 32'd316);
            if (k == 48) chk("arc_n47", 32'(doodle_y), 32'd316);
            if (k == 48) chk("arc_fall47", 32'(falling), 32'd0);
            if (k == 49) chk("arc_fall48", 32'(falling), 32'd1);
        end

        // Normal landing
        tick(1, 0, 1, 400, 0, 0);
        chk("land_y", 32'(doodle_y), 32'd319);
        chk("land_n", 32'(jump_n), 32'd1);
        tick(1, 0, 0, 0, 0, 0);
        chk("land_next", 32'(doodle_y), 32'd310);

        // Rise and fall again, then land on a spring
        guard = 0;
        while (mfall == 0 && guard < 120) begin
            tick(1, 0, 0, 0, 0, 0);
            guard++;
        end
        chk("refall_bound", 32'(guard < 120), 32'd1);
        tick(1, 0, 1, 400, 1, 0);
        chk("spring_y", 32'(doodle_y), 32'd319);
        tick(1, 0, 0, 0, 0, 0);
        chk("spring_next", 32'(doodle_y), 32'd304);
        tick(1, 0, 1, 400, 0, 0);
        chk("rising_land_ignored", 32'(jump_n), 32'd3);

        // Horizontal wrap and facing
        tick(1, 168, 0, 0, 0, 0);
        tick(1, 5, 0, 0, 0, 0);
        chk("wrap_right", 32'(doodle_x), 32'd303);
        tick(1, -1, 0, 0, 0, 0);
        tick(1, -5, 0, 0, 0, 0);
        chk("wrap_left", 32'(doodle_x), 32'd639);
        chk("face_left", 32'(facing_left), 32'd1);
        tick(1, 0, 0, 0, 0, 0);
        chk("face_hold", 32'(facing_left), 32'd1);

        // Landing and scroll on the same tick, then the full burst
        do_reset();
        for (int k = 0; k < 49; k++) tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 400, 0, 1);
        chk("land_scroll", 32'(doodle_y), 32'd331);
        for (int k = 0; k < 17; k++) tick(1, 3, 0, 0, 0, 0);
        chk("scroll_done", 32'(msc), 32'd0);

        // Reset in the middle of a scroll burst, on a tick cycle
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0);
        rst = 1'b1; frame_tick = 1'b1; game_state = 2'd1; scroll_start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; frame_tick = 1'b0; scroll_start = 1'b0;
        model_reset();
        check_all("rst_mid");
        tick(1, 0, 0, 0, 0, 0);
        chk("post_rst_y0", 32'(doodle_y), 32'd519);
        tick(1, 0, 0, 0, 0, 0);
        chk("post_rst_y1", 32'(doodle_y), 32'd510);

        // Fall off the floor in play: exactly one fell_out cycle
        fell_seen = 0;
        guard = 0;
        while (my < 600 && guard < 200) begin
            tick(1, 0, 0, 0, 0, 0);
            guard++;
        end
        chk("fall_bound", 32'(guard < 200), 32'd1);
        for (int k = 0; k < 20; k++) tick(1, 0, 0, 0, 0, 0);
        chk("fell_pulses", 32'(fell_seen), 32'd1);

        // Game-over fall: x frozen, landing and scroll ignored
        do_reset();
        for (int k = 0; k < 10; k++) tick(1, int'($urandom_range(0, 40)) - 20, 0, 0, 0, 0);
        saved_x = mx;
        guard = 0;
        while (moff == 0 && guard < 200) begin
            tick(2, 7, 1, 300, 1, 1);
            guard++;
        end
        chk("over_bound", 32'(guard < 200), 32'd1);
        chk("over_y", 32'(doodle_y), 32'd600);
        chk("over_off", 32'(off_screen), 32'd1);
        chk("over_x", 32'(doodle_x), 32'(saved_x));
        tick(2, 7, 1, 300, 0, 1);
        chk("over_hold_y", 32'(doodle_y), 32'd600);

        // Pause holds everything
        for (int k = 0; k < 5; k++)
            tick(3, int'($urandom_range(0, 40)) - 20, 1, 350, 1, 1);
        chk("pause_y", 32'(doodle_y), 32'd600);
        chk("pause_x", 32'(doodle_x), 32'(saved_x));

        // Random play against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            gs = (r < 85) ? 1 : (r < 89) ? 0 : (r < 94) ? 2 : 3;
            tick(gs, int'($urandom_range(0, 60)) - 30,
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(60, 800)),
                 1'($urandom), 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/doodle_motion.md
# doodle_motion

Parametrised player-motion engine for the jumping character: integrates horizontal steering with screen wrap, ballistic vertical motion, platform landing, spring boost, camera-scroll offset and a game-over fall. It sits between the collision/platform logic and the sprite renderer. It owns only position and state; it produces no pixel colour. All updates occur on a one-cycle frame tick.

## Interface
- X_W, 11, x coordinate width
- Y_W, 10, y coordinate width
- CNT_W, 8, jump-frame counter width
- X_MIN, 300, left wrap bound (inclusive)
- X_MAX, 642, right wrap bound (exclusive)
- SPRITE_H, 80, sprite height in pixels
- EARTH, 600, y of screen floor
- START_X, 472, reset/idle x
- VELOCITY, 9, normal take-off speed (px/frame)
- BOOST_VELOCITY, 15, spring take-off speed
- ACCELERATION, 2, gravity in tenths px/frame²
- SCROLL_STEP, 12, px added to y per scroll frame
- SCROLL_FRAMES, 16, frames per scroll burst

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- game_state  in  2  0 idle, 1 play, 2 game-over, 3 pause
- delta_x  in  9 signed  horizontal step this frame
- land  in  1  platform contact this frame
- land_y  in  Y_W  top y of contacted platform
- spring  in  1  contact is a spring (valid with land)
- scroll_start  in  1  start a scroll burst
- doodle_x  out  X_W  sprite left edge
- doodle_y  out  Y_W  sprite top edge
- falling  out  1  y increased on last tick
- facing_left  out  1  sprite orientation
- jump_n  out  CNT_W  frames since take-off
- fell_out  out  1  one-cycle pulse: fell below EARTH in play
- off_screen  out  1  game-over fall complete

## Operation
- Internal: base_y (Y_W), y_prev, n (CNT_W), vel (selected take-off speed), scroll counter. START_Y = EARTH − SPRITE_H − 1.
- Ballistic y = base_y − vel·n + ⌊ACCELERATION·n²/20⌋. Compute signed 32-bit. Clamp results < 0 to 0 and results > 2^Y_W−1 to 2^Y_W−1. n saturates at 2^CNT_W−1.
- Idle (0): x=START_X, y=base_y=START_Y, n=0, vel=VELOCITY, scroll cleared, off_screen=0.
- Play (1), per tick:
  - x: nx = x + delta_x. If nx < X_MIN, add (X_MAX−X_MIN). If nx ≥ X_MAX, subtract (X_MAX−X_MIN).
  - facing_left: 1 if delta_x < 0, 0 if > 0, held if 0.
  - Landing is accepted only when land && falling. It sets base_y = land_y − SPRITE_H − 1, y = base_y, n = 1, vel = spring ? BOOST_VELOCITY : VELOCITY.
  - Otherwise y = ballistic(n) and n++.
  - Scroll: scroll_start loads the counter with SCROLL_FRAMES. While the counter is nonzero, SCROLL_STEP is added to both base_y and the new y, and the counter decrements. scroll_start while active reloads the counter.
  - Once per fall: new y ≥ EARTH pulses fell_out. It rearms on landing.
- Game-over (2): ballistic continues; land and scroll_start are ignored; x is frozen. When new y ≥ EARTH, clamp y=EARTH, stop n, set off_screen.
- Pause (3): all state is held.
- falling = (new y > previous y), strict. It is updated on ticks in states 1 and 2, and cleared in idle.

## Timing
- Every state and output changes only on the cycle after a clk edge with frame_tick=1. Registered outputs are valid one cycle after the tick.
- land, land_y, spring, scroll_start and delta_x are sampled only on the tick cycle. Between ticks they are don't-care.
- Reset values: doodle_x=START_X, doodle_y=START_Y, falling=0, facing_left=0, jump_n=0, fell_out=0, off_screen=0. Scroll counter = 0.
- rst mid-jump or mid-scroll returns every register to its reset value on the next edge. rst has priority over frame_tick.
- Simultaneous landing and scroll on one tick: landing sets base_y first, then the scroll step is added.

## Test plan
- Reset, game_state=1, no land, delta_x=0, 48 ticks → y: 510 at n=1, 476 at n=5, 316 at n=44/45/47; falling=0 through n=47 and 1 at n=48.
- Start with x=640 and delta_x=+5 → x=303. Start with x=302 and delta_x=−5 → x=639. facing_left becomes 1 on a negative step and holds with delta_x=0.
- Falling, land=1, land_y=400, spring=0 → y=319, jump_n=1, next y=310. Repeat with spring=1 → next y=304. land while rising → ignored.
- scroll_start with SCROLL_FRAMES=16, SCROLL_STEP=12 → 16 ticks of +12 added to base_y. Landing on the same tick as scroll_start → y = land_y − 81 + 12.
- Play fall past EARTH → fell_out high exactly one cycle. game_state=2 → y rises to EARTH, off_screen=1, land ignored. game_state=3 → all outputs frozen across ticks.
- rst asserted mid-scroll on a tick cycle → all reset values next cycle; no scroll offset applied afterward.
